// File: rtl/mem_access_stage.sv
// Memory access stage: word load/store on an internal data RAM with wait states.
// Ports: clk, reset (async high); in_valid/mem_read/mem_write/alu_result/wdata in;
//        stall, out_valid, result, err out (out_valid/result/err registered).
module mem_access_stage #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] alu_result,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] result,
    output logic        err
);

    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              lat_read;
    logic [ADDR_W-1:0] lat_idx;
    logic [31:0]       lat_wdata;

    logic [31:0]       ram [DEPTH];

    logic              accept;
    logic              is_mem;
    logic              illegal;
    logic [ADDR_W-1:0] in_idx;
    logic [ADDR_W-1:0] acc_idx;
    logic [31:0]       acc_wdata;
    logic              do_access;
    logic              acc_store;
    logic              we;
    logic [31:0]       rd_data;

    assign stall   = (state == WAIT);
    assign accept  = in_valid && (state == IDLE);
    assign is_mem  = mem_read || mem_write;
    assign illegal = is_mem &&
                     ((alu_result[1:0] != 2'b00) || (mem_read && mem_write));
    assign in_idx  = alu_result[ADDR_W+1:2];

    // The access is performed either on the accept edge (zero wait states)
    // or on the final WAIT edge using the latched operation.
    always_comb begin
        acc_idx   = in_idx;
        acc_wdata = wdata;
        do_access = 1'b0;
        acc_store = 1'b0;
        if (state == WAIT) begin
            acc_idx   = lat_idx;
            acc_wdata = lat_wdata;
            do_access = (cnt == 4'd1);
            acc_store = !lat_read;
        end else if (LAT == 4'd0 && accept && is_mem && !illegal) begin
            do_access = 1'b1;
            acc_store = mem_write;
        end
    end

    assign we      = do_access && acc_store;
    assign rd_data = ram[acc_idx];

    // RAM contents are deliberately not reset. The write enable is derived
    // from registered state, so reset during WAIT cancels a pending store.
    always_ff @(posedge clk) begin
        if (we) begin
            ram[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_read  <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
            out_valid <= 1'b0;
            result    <= 32'd0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        unique case (1'b1)
                            !is_mem: begin
                                out_valid <= 1'b1;
                                result    <= alu_result;
                            end
                            illegal: begin
                                out_valid <= 1'b1;
                                err       <= 1'b1;
                                result    <= 32'd0;
                            end
                            (LAT == 4'd0): begin
                                out_valid <= 1'b1;
                                result    <= mem_read ? rd_data : 32'd0;
                            end
                            default: begin
                                lat_read  <= mem_read;
                                lat_idx   <= in_idx;
                                lat_wdata <= wdata;
                                cnt       <= LAT;
                                state     <= WAIT;
                            end
                        endcase
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        out_valid <= 1'b1;
                        result    <= lat_read ? rd_data : 32'd0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with LATENCY=2, DEPTH=256.
// Drives ops right after each rising edge and checks outputs 1 ns later.
module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] alu_result;
    logic [31:0] wdata;
    logic        stall;
    logic        out_valid;
    logic [31:0] result;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_stage #(.DEPTH(256), .ADDR_W(8), .LATENCY(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .alu_result(alu_result),
        .wdata     (wdata),
        .stall     (stall),
        .out_valid (out_valid),
        .result    (result),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic issue(input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        in_valid   = 1'b1;
        mem_read   = r;
        mem_write  = w;
        alu_result = a;
        wdata      = d;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic s, input logic e,
                           input logic [31:0] r);
        check({tag, ".ov"}, {31'd0, out_valid}, {31'd0, v});
        check({tag, ".stall"}, {31'd0, stall}, {31'd0, s});
        check({tag, ".err"}, {31'd0, err}, {31'd0, e});
        check({tag, ".res"}, result, r);
    endtask

    // Memory op with LATENCY=2: two stalled cycles, then the pulse.
    task automatic mem_op(input string tag, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] prev, input logic [31:0] exp);
        issue(r, w, a, d);
        tick();
        chk_out({tag, ".w1"}, 1'b0, 1'b1, 1'b0, prev);
        tick();
        chk_out({tag, ".w2"}, 1'b0, 1'b1, 1'b0, prev);
        tick();
        idle();
        chk_out({tag, ".done"}, 1'b1, 1'b0, 1'b0, exp);
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_result = 32'd0;
        wdata      = 32'd0;
        tick();
        tick();
        chk_out("reset", 1'b0, 1'b0, 1'b0, 32'd0);
        reset = 1'b0;

        // 1: pass-through
        issue(1'b0, 1'b0, 32'h0000_0005, 32'd0);
        tick();
        idle();
        chk_out("pt5", 1'b1, 1'b0, 1'b0, 32'd5);
        tick();
        chk_out("pt5.hold", 1'b0, 1'b0, 1'b0, 32'd5);

        // 2: store then load, 2 wait states each
        mem_op("sw10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'd5, 32'd0);
        mem_op("lw10", 1'b1, 1'b0, 32'h10, 32'd0, 32'd0, 32'hDEAD_BEEF);

        // 3: misaligned and read+write both set
        issue(1'b1, 1'b0, 32'h0000_0402, 32'd0);
        tick();
        chk_out("mis", 1'b1, 1'b0, 1'b1, 32'd0);
        issue(1'b1, 1'b1, 32'h10, 32'h5555_5555);
        tick();
        idle();
        chk_out("rw", 1'b1, 1'b0, 1'b1, 32'd0);
        tick();
        chk_out("rw.idle", 1'b0, 1'b0, 1'b0, 32'd0);
        mem_op("lw10b", 1'b1, 1'b0, 32'h10, 32'd0, 32'd0, 32'hDEAD_BEEF);

        // 4: address wrap modulo 1 KiB
        mem_op("sw404", 1'b0, 1'b1, 32'h404, 32'h1234, 32'hDEAD_BEEF, 32'd0);
        mem_op("lw4", 1'b1, 1'b0, 32'h4, 32'd0, 32'd0, 32'h1234);

        // 5: reset aborts a pending store
        mem_op("sw20z", 1'b0, 1'b1, 32'h20, 32'd0, 32'h1234, 32'd0);
        issue(1'b0, 1'b0, 32'h77, 32'd0);
        tick();
        chk_out("pt77", 1'b1, 1'b0, 1'b0, 32'h77);
        issue(1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF);
        tick();
        chk_out("sw20f.w1", 1'b0, 1'b1, 1'b0, 32'h77);
        reset = 1'b1;
        idle();
        #1;
        chk_out("abort", 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        mem_op("lw20", 1'b1, 1'b0, 32'h20, 32'd0, 32'd0, 32'd0);

        // 6: back-to-back pass-through, then a load
        issue(1'b0, 1'b0, 32'd1, 32'd0);
        tick();
        chk_out("b2b1", 1'b1, 1'b0, 1'b0, 32'd1);
        issue(1'b0, 1'b0, 32'd2, 32'd0);
        tick();
        chk_out("b2b2", 1'b1, 1'b0, 1'b0, 32'd2);
        issue(1'b0, 1'b0, 32'd3, 32'd0);
        tick();
        chk_out("b2b3", 1'b1, 1'b0, 1'b0, 32'd3);
        mem_op("b2blw", 1'b1, 1'b0, 32'h4, 32'd0, 32'd3, 32'h1234);
        tick();
        chk_out("end", 1'b0, 1'b0, 1'b0, 32'h1234);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
